// File: rtl/byte_mem_seq_pkg.sv
// Shared encodings for the byte-serial memory sequencer: access size codes,
// FSM state enum and size helpers.
package byte_mem_seq_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Limit a size code to the widest access the datapath can hold.
  function automatic logic [1:0] clamp_size(input logic [1:0] size,
                                            input logic [1:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

  function automatic logic [3:0] size_to_nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/byte_mem_seq_extend.sv
// Combinational sign/zero extender for an assembled little-endian load value.
// The size input is expected to be already clamped to the datapath width.
module byte_mem_seq_extend
  import byte_mem_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] din,
  input  logic [1:0]      size,
  input  logic            is_signed,
  output logic [XLEN-1:0] dout
);

  logic [3:0]      nbytes;
  logic [6:0]      msb_pos;
  logic [XLEN-1:0] shifted;
  logic            fill;
  int              nbits;

  always_comb begin
    nbytes  = size_to_nbytes(size);
    msb_pos = {nbytes, 3'b000} - 7'd1;
    shifted = din >> msb_pos;
    fill    = is_signed & shifted[0];
    nbits   = 8 * int'(nbytes);
    for (int i = 0; i < XLEN; i++) begin
      dout[i] = (i < nbits) ? din[i] : fill;
    end
  end

endmodule

// File: rtl/byte_mem_sequencer.sv
// Executes one 1/2/4/8-byte load/store as a little-endian run of byte accesses
// with wait states. Optional feature macro: MEM_ALIGN_CHK_EN (alignment/size error check).
module byte_mem_sequencer
  import byte_mem_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output state_t            dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. rsp_valid is a single-cycle pulse with no ready.

  localparam logic [1:0] MAX_SIZE = (XLEN == 64) ? SZ_D : SZ_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   asm_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              signed_q;
  logic              err_q;
  logic [2:0]        idx_q;
  logic [2:0]        last_q;

  logic              accept;
  logic              byte_done;
  logic              last_byte;
  logic              req_bad;
  logic [1:0]        acc_size;
  logic [3:0]        acc_nbytes;
  logic [XLEN-1:0]   ext_data;

  assign accept     = (state == ST_IDLE) && req_valid;
  assign byte_done  = (state == ST_ACCESS) && mem_ack;
  assign last_byte  = (idx_q == last_q);
  assign acc_size   = clamp_size(req_size, MAX_SIZE);
  assign acc_nbytes = size_to_nbytes(acc_size);
  assign dbg_state  = state;

`ifdef MEM_ALIGN_CHK_EN
  logic [3:0] raw_nbytes;
  assign raw_nbytes = size_to_nbytes(req_size);
  // Oversized or misaligned requests skip the memory and answer with an error.
  assign req_bad = (req_size > MAX_SIZE) ||
                   ((req_addr[2:0] & (raw_nbytes[2:0] - 3'd1)) != 3'd0);
`else
  assign req_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = req_bad ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (mem_ack && last_byte) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      size_q   <= SZ_B;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      last_q   <= '0;
    end else if (accept) begin
      base_q   <= req_addr;
      wdata_q  <= req_wdata;
      asm_q    <= '0;
      size_q   <= acc_size;
      write_q  <= req_write;
      signed_q <= req_signed;
      err_q    <= req_bad;
      idx_q    <= '0;
      last_q   <= 3'(acc_nbytes - 4'd1);
    end else if (byte_done) begin
      if (!write_q) asm_q <= asm_q | (XLEN'(mem_rdata) << {idx_q, 3'b000});
      if (!last_byte) idx_q <= idx_q + 3'd1;
    end
  end

  byte_mem_seq_extend #(
    .XLEN(XLEN)
  ) u_extend (
    .din      (asm_q),
    .size     (size_q),
    .is_signed(signed_q),
    .dout     (ext_data)
  );

  // Outputs decode from the registered state so an asynchronous reset drops them at once.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: req_ready = !reset;
      ST_ACCESS: begin
        mem_addr  = base_q + ADDR_W'(idx_q);
        mem_re    = !write_q;
        mem_we    = write_q;
        mem_wdata = 8'(wdata_q >> {idx_q, 3'b000});
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = (write_q || err_q) ? '0 : ext_data;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_byte_mem_sequencer.sv
// Bench for byte_mem_sequencer: directed spec vectors plus randomized requests
// against a byte-array reference memory.
module tb_byte_mem_sequencer;
  import byte_mem_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  state_t      dbg_state;

  byte_mem_sequencer #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder ----------------
  logic [7:0]  mem_arr [0:255];
  logic [7:0]  ref_mem [0:255];
  int          cur_wait = 0;
  int          waited = 0;
  int          wait_cnt = 0;
  int          stab_err = 0;
  logic [31:0] acc_q[$];
  logic        hold_v = 1'b0;
  logic [41:0] hold_sig = '0;

  always @(negedge clk) begin
    if (mem_re || mem_we) begin
      if (waited >= cur_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_arr[mem_addr[7:0]];
        waited    = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        waited++;
      end
    end else begin
      mem_ack = 1'b0;
      waited  = 0;
    end
  end

  always @(posedge clk) begin
    logic [41:0] sig;
    sig = {mem_re, mem_we, mem_wdata, mem_addr};
    if (mem_re || mem_we) begin
      if (hold_v && (sig !== hold_sig)) stab_err++;
      if (mem_ack) begin
        acc_q.push_back(mem_addr);
        if (mem_we) mem_arr[mem_addr[7:0]] = mem_wdata;
        hold_v = 1'b0;
      end else begin
        wait_cnt++;
        hold_v   = 1'b1;
        hold_sig = sig;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          last_lat = 0;
  logic [31:0] last_rdata = '0;

  function automatic int ref_nbytes(input logic [1:0] sz);
    return (sz > 2'd2) ? 4 : (1 << sz);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sg);
    longint v;
    int nb;
    v  = 0;
    nb = ref_nbytes(sz);
    for (int k = 0; k < nb; k++) v += longint'(ref_mem[8'(a + 32'(k))]) << (8 * k);
    if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int k = 0; k < ref_nbytes(sz); k++) ref_mem[8'(a + 32'(k))] = 8'(wd >> (8 * k));
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    mem_arr[a] = d;
    ref_mem[a] = d;
  endtask

  // ---------------- driver ----------------
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int wt);
    int nb, exp_lat, exp_acc, cyc, a0, w0, got;
    logic bad, seen;
    logic [31:0] exp_rd, ea;
    nb  = ref_nbytes(sz);
    bad = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    bad = (sz > 2'd2) || ((a % (32'd1 << sz)) != 0);
`endif
    exp_lat = bad ? 1 : nb * (wt + 1) + 1;
    exp_acc = bad ? 0 : nb;
    exp_rd  = (bad || wr) ? 32'h0 : ref_load(a, sz, sg);
    if (wr && !bad) ref_store(a, sz, wd);
    exp_q.push_back(exp_rd);
    a0 = acc_q.size();
    w0 = wait_cnt;
    @(negedge clk);
    cur_wait = wt;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc  = 1;
    seen = rsp_valid;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      seen = rsp_valid;
    end
    check("rsp_seen", seen, 1);
    last_lat   = cyc;
    last_rdata = rsp_rdata;
    check("rsp_latency", cyc, exp_lat);
    check("rsp_rdata", rsp_rdata, exp_q.pop_front());
    check("rsp_err", rsp_err, bad);
    check("req_ready_resp", req_ready, 0);
    @(negedge clk);
    check("rsp_pulse_width", rsp_valid, 0);
    got = acc_q.size() - a0;
    check("acc_count", got, exp_acc);
    for (int k = 0; k < got && k < exp_acc; k++) begin
      ea = a + 32'(k);
      check("acc_addr", acc_q[a0 + k], ea);
    end
    check("wait_cycles", wait_cnt - w0, bad ? 0 : nb * wt);
    if (wr) begin
      for (int k = 0; k < nb; k++) check("mem_byte", mem_arr[8'(a + 32'(k))], ref_mem[8'(a + 32'(k))]);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] w, exp_rd, ra;
    logic [1:0]  rs;

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    #1 check("rst_release_ready", req_ready, 1);

    // LW zero-wait
    poke(8'h10, 8'h78); poke(8'h11, 8'h56); poke(8'h12, 8'h34); poke(8'h13, 8'h12);
    run_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 0);
`ifndef MEM_ALIGN_CHK_EN
    check("lw_value", last_rdata, 32'h1234_5678);
    check("lw_cycle", last_lat, 5);
`endif

    // LB signed / unsigned
    poke(8'h20, 8'h80);
    run_req(1'b0, SZ_B, 1'b1, 32'h20, 32'h0, 0);
    check("lb_signed", last_rdata, 32'hFFFF_FF80);
    run_req(1'b0, SZ_B, 1'b0, 32'h20, 32'h0, 0);
    check("lb_unsigned", last_rdata, 32'h0000_0080);
    check("lb_cycle", last_lat, 2);

    // SH with two wait states per byte
    poke(8'h31, 8'h00); poke(8'h32, 8'h00);
    run_req(1'b1, SZ_H, 1'b0, 32'h31, 32'h0000_BEEF, 2);
`ifndef MEM_ALIGN_CHK_EN
    check("sh_byte0", mem_arr[8'h31], 8'hEF);
    check("sh_byte1", mem_arr[8'h32], 8'hBE);
    check("sh_cycle", last_lat, 7);
`endif
    check("strobe_stable", stab_err, 0);

    // LW across the address wrap
    run_req(1'b0, SZ_W, 1'b1, 32'hFFFF_FFFE, 32'h0, 1);

    // reset during byte 2 of a SW
    for (int k = 0; k < 4; k++) poke(8'(8'h60 + k), 8'h00);
    w = $urandom;
    cur_wait = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_W; req_signed = 1'b0;
    req_addr = 32'h60; req_wdata = w;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_addr", mem_addr, 32'h62);
    check("mid_we", mem_we, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_we_drop", mem_we, 0);
    check("mid_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_ready_low", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_rsp", rsp_valid, 0);
    end
    reset = 1'b0;
    #1 check("post_rst_ready", req_ready, 1);
    ref_mem[8'h60] = w[7:0];
    ref_mem[8'h61] = w[15:8];
    for (int k = 0; k < 4; k++) check("mid_mem", mem_arr[8'(8'h60 + k)], ref_mem[8'(8'h60 + k)]);

    // req_valid held through a busy period; inputs changed while busy are ignored
    poke(8'h50, 8'h00);
    cur_wait = 0;
    exp_rd = ref_load(32'h40, SZ_B, 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_B; req_signed = 1'b1;
    req_addr = 32'h40; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check("hold_busy_ready", req_ready, 0);
    req_addr = 32'h50; req_write = 1'b1; req_wdata = 32'h5A; req_signed = 1'b0;
    @(negedge clk);
    check("hold_rsp_valid", rsp_valid, 1);
    check("hold_rsp_rdata", rsp_rdata, exp_rd);
    @(negedge clk);
    check("hold_ready_back", req_ready, 1);
    ref_store(32'h50, SZ_B, 32'h5A);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("hold_store_rsp", rsp_valid, 1);
    check("hold_store_rdata", rsp_rdata, 0);
    @(negedge clk);
    check("hold_store_mem", mem_arr[8'h50], ref_mem[8'h50]);

    // randomized requests
    for (int n = 0; n < 40; n++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra & ~32'((ref_nbytes(rs)) - 1);
      run_req(1'($urandom), rs, 1'($urandom), ra, $urandom, $urandom_range(0, 2));
    end
    check("strobe_stable_final", stab_err, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
